// File: rtl/sram_bist_master.sv
// BIST initiator for sram_top: writes PATTERN to every word, reads each back and compares.
// Define SRAM_BIST_INV_PASS_EN to append a second write/read pass using ~PATTERN.
module sram_bist_master #(
    parameter int                WIDTH      = 4,
    parameter int                DEPTH      = 32,
    parameter int                ADDR_WIDTH = $clog2(DEPTH),
    parameter logic [WIDTH-1:0]  PATTERN    = 4'b1010,
    parameter int                GAP        = 1,
    parameter int                RD_LAT     = 2,
    localparam int               ERR_W      = $clog2(2*DEPTH+1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  wr_req,
    output logic                  re_req,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic [WIDTH-1:0]      din_out,
    input  logic [WIDTH-1:0]      dout_in,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_W-1:0]      err_cnt,
    output logic [ADDR_WIDTH-1:0] fail_addr
);

    localparam int WMAX  = (GAP > RD_LAT) ? GAP : RD_LAT;
    localparam int CNT_W = $clog2(WMAX + 1);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, DONE} state_t;

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] addr, addr_n;
    logic [CNT_W-1:0]      wcnt, wcnt_n;
    logic                  phase, phase_n;
    logic [ERR_W-1:0]      err_n;
    logic [ADDR_WIDTH-1:0] fail_n;
    logic [WIDTH-1:0]      exp_pat;
    logic                  last_addr;

    assign exp_pat   = phase ? ~PATTERN : PATTERN;
    assign last_addr = (addr == ADDR_WIDTH'(DEPTH - 1));

    always_comb begin
        state_n = state;
        addr_n  = addr;
        wcnt_n  = wcnt;
        phase_n = phase;
        err_n   = err_cnt;
        fail_n  = fail_addr;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = WR_REQ;
                    addr_n  = '0;
                    wcnt_n  = '0;
                    phase_n = 1'b0;
                    err_n   = '0;
                    fail_n  = '0;
                end
            end
            WR_REQ: begin
                state_n = WR_WAIT;
                wcnt_n  = '0;
            end
            WR_WAIT: begin
                if (wcnt == CNT_W'(GAP - 1)) begin
                    if (last_addr) begin
                        addr_n  = '0;
                        state_n = RD_REQ;
                    end else begin
                        addr_n  = addr + ADDR_WIDTH'(1);
                        state_n = WR_REQ;
                    end
                end else begin
                    wcnt_n = wcnt + CNT_W'(1);
                end
            end
            RD_REQ: begin
                state_n = RD_WAIT;
                wcnt_n  = '0;
            end
            RD_WAIT: begin
                if (wcnt == CNT_W'(RD_LAT - 1)) begin
                    // err_cnt==0 means no earlier mismatch, so this is the first one
                    if (dout_in != exp_pat) begin
                        if (err_cnt != {ERR_W{1'b1}}) err_n = err_cnt + ERR_W'(1);
                        if (err_cnt == '0) fail_n = addr;
                    end
                    if (last_addr) begin
`ifdef SRAM_BIST_INV_PASS_EN
                        if (!phase) begin
                            phase_n = 1'b1;
                            addr_n  = '0;
                            state_n = WR_REQ;
                        end else begin
                            state_n = DONE;
                        end
`else
                        state_n = DONE;
`endif
                    end else begin
                        addr_n  = addr + ADDR_WIDTH'(1);
                        state_n = RD_REQ;
                    end
                end else begin
                    wcnt_n = wcnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next-state view so they line up with the state they describe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            wcnt      <= '0;
            phase     <= 1'b0;
            wr_req    <= 1'b0;
            re_req    <= 1'b0;
            addr_out  <= '0;
            din_out   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_cnt   <= '0;
            fail_addr <= '0;
        end else begin
            state     <= state_n;
            addr      <= addr_n;
            wcnt      <= wcnt_n;
            phase     <= phase_n;
            wr_req    <= (state_n == WR_REQ);
            re_req    <= (state_n == RD_REQ);
            if (state_n == WR_REQ || state_n == RD_REQ) addr_out <= addr_n;
            if (state_n == WR_REQ) din_out <= phase_n ? ~PATTERN : PATTERN;
            busy      <= (state_n != IDLE) && (state_n != DONE);
            done      <= (state_n == DONE);
            pass      <= (state_n == DONE) && (err_n == '0);
            err_cnt   <= err_n;
            fail_addr <= fail_n;
        end
    end

endmodule

// File: tb/tb_sram_bist_master.sv
// Directed bench for sram_bist_master with a small sram_top read/write model and fault injection.
module tb_sram_bist_master;

    localparam int WIDTH = 4;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int EW    = $clog2(2*DEPTH+1);
    localparam logic [WIDTH-1:0] PAT = 4'b1010;
`ifdef SRAM_BIST_INV_PASS_EN
    localparam int NPASS = 2;
`else
    localparam int NPASS = 1;
`endif
    localparam int RUN_EDGES = NPASS * (DEPTH*2 + DEPTH*3);

    logic clk = 1'b0;
    logic rst, start;
    logic wr_req, re_req, busy, done, pass;
    logic [AW-1:0] addr_out, fail_addr;
    logic [WIDTH-1:0] din_out, dout_in;
    logic [EW-1:0] err_cnt;

    sram_bist_master dut (
        .clk(clk), .rst(rst), .start(start),
        .wr_req(wr_req), .re_req(re_req), .addr_out(addr_out), .din_out(din_out),
        .dout_in(dout_in), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .fail_addr(fail_addr)
    );

    always #5 clk = ~clk;

    // sram_top model: data appears two edges after the request edge, garbage otherwise
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] r_data;
    logic             v1;
    int               mode;

    function automatic logic [WIDTH-1:0] inject(input logic [WIDTH-1:0] d, input logic [AW-1:0] a);
        logic [WIDTH-1:0] r;
        r = d;
        if (mode == 1) r[0] = 1'b1;
        if (mode == 2 && a == AW'(17)) r = '0;
        return r;
    endfunction

    always @(posedge clk) begin
        if (wr_req) mem[addr_out] <= din_out;
        v1 <= re_req;
        if (re_req) r_data <= inject(mem[addr_out], addr_out);
        dout_in <= v1 ? r_data : 4'h3;
    end

    // Protocol monitor
    logic mon_clr;
    int   wr_cnt, rd_cnt, proto_bad, seq_bad, din_bad;
    logic prev_req;

    always @(negedge clk) begin
        if (mon_clr) begin
            wr_cnt = 0; rd_cnt = 0; proto_bad = 0; seq_bad = 0; din_bad = 0; prev_req = 1'b0;
        end else begin
            if (wr_req && re_req) proto_bad++;
            if ((wr_req || re_req) && prev_req) proto_bad++;
            prev_req = wr_req || re_req;
            if (wr_req) begin
                if (addr_out !== AW'(wr_cnt % DEPTH)) seq_bad++;
                if (din_out !== (((wr_cnt / DEPTH) != 0) ? ~PAT : PAT)) din_bad++;
                wr_cnt++;
            end
            if (re_req) begin
                if (addr_out !== AW'(rd_cnt % DEPTH)) seq_bad++;
                rd_cnt++;
            end
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse start, optionally re-pulse it at edge 'poke', count edges until done (bounded)
    task automatic run(input int poke, output int edges);
        @(posedge clk); #1 mon_clr = 1'b1;
        @(negedge clk); #1 mon_clr = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        edges = 0;
        while (!done && edges < 1000) begin
            start = (edges == poke);
            @(posedge clk); #1;
            edges++;
        end
        start = 1'b0;
    endtask

    task automatic chk_result(input string tag, input int edges, input int e_err,
                              input int e_fail, input logic e_pass);
        chk({tag, "_edges"}, edges, RUN_EDGES);
        chk({tag, "_err"}, err_cnt, e_err);
        chk({tag, "_fail"}, fail_addr, e_fail);
        chk({tag, "_pass"}, pass, e_pass);
        chk({tag, "_done_busy"}, {done, busy}, 2'b10);
        chk({tag, "_wr_cnt"}, wr_cnt, NPASS*DEPTH);
        chk({tag, "_rd_cnt"}, rd_cnt, NPASS*DEPTH);
        chk({tag, "_proto"}, proto_bad, 0);
        chk({tag, "_seq"}, seq_bad, 0);
        chk({tag, "_din"}, din_bad, 0);
    endtask

    initial begin
        int e;
        rst = 1'b1; start = 1'b0; mode = 0; mon_clr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {wr_req, re_req, addr_out, din_out, busy, done, pass, err_cnt, fail_addr}, 0);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("idle_outputs", {wr_req, re_req, busy, done, pass}, 0);

        mode = 0; run(-1, e);
        chk_result("clean", e, 0, 0, 1'b1);

        mode = 1; run(-1, e);
        chk_result("stuck", e, DEPTH, 0, 1'b0);

        mode = 2; run(-1, e);
        chk_result("single", e, NPASS, 17, 1'b0);

        mode = 0; run(40, e);
        chk_result("ignore", e, 0, 0, 1'b1);

        // Abort during RD_WAIT at address 5 (second wait cycle after edge 81)
        @(posedge clk); #1 mon_clr = 1'b1;
        @(negedge clk); #1 mon_clr = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (81) @(posedge clk);
        #1 chk("abort_rd_cnt", rd_cnt, 6);
        chk("abort_busy_before", busy, 1'b1);
        #2 rst = 1'b1;
        #1 chk("abort_outputs", {wr_req, re_req, addr_out, din_out, busy, done, pass, err_cnt, fail_addr}, 0);
        @(negedge clk) rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("abort_stays_idle", {wr_req, re_req, busy, done}, 0);

        run(-1, e);
        chk_result("rerun", e, 0, 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_bist_master.md
Name: sram_bist_master

Overview:
- Requester-side controller that drives the sram_top request interface: wr_req/re_req pulses, address and write data.
- On start, writes a fixed pattern to every address, then reads each address back and compares against the expected value.
- Reports busy, done, pass, an error count and the first failing address.
- Sits in front of sram_top as its built-in self-test initiator, in place of a bench or host driving requests.

Parameters:
- WIDTH, 4, data width; must match sram_top WIDTH.
- DEPTH, 32, number of words; must match sram_top DEPTH.
- ADDR_WIDTH, $clog2(DEPTH), address width.
- PATTERN, 4'b1010, write/expect data word (WIDTH bits).
- GAP, 1, idle cycles after each wr_req pulse before the next request (>=1).
- RD_LAT, 2, cycles from re_req pulse to valid dout_in (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a test run; sampled in IDLE or DONE only.
- wr_req  output  1  one-cycle write request to sram_top.
- re_req  output  1  one-cycle read request to sram_top.
- addr_out  output  ADDR_WIDTH  request address to sram_top addr_in.
- din_out  output  WIDTH  write data to sram_top din_in.
- dout_in  input  WIDTH  read data from sram_top dout_out.
- busy  output  1  high from the first request cycle until done.
- done  output  1  high in DONE until next start or reset.
- pass  output  1  done && err_cnt==0, registered.
- err_cnt  output  $clog2(2*DEPTH+1)  mismatch count, saturating.
- fail_addr  output  ADDR_WIDTH  address of first mismatch; 0 if none.

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous, active-high.
- Registered outputs: all outputs are registered. Reset value of every output is 0. FSM resets to IDLE; address counter and wait counter reset to 0.
- Reset mid-run: reset at any point aborts the run immediately, with no further requests.
- FSM states: IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, DONE.
- IDLE:
  - start=1 at an edge -> WR_REQ; clears err_cnt, fail_addr, done and pass; addr=0; busy=1.
- WR_REQ (1 cycle):
  - wr_req=1, addr_out=addr, din_out=PATTERN -> WR_WAIT.
- WR_WAIT (GAP cycles):
  - wr_req=0; addr_out and din_out hold.
  - On the last cycle: if addr==DEPTH-1, go to RD_REQ with addr=0 (wrap); otherwise addr+1 and go to WR_REQ.
- RD_REQ (1 cycle):
  - re_req=1, addr_out=addr -> RD_WAIT.
- RD_WAIT (RD_LAT cycles):
  - re_req=0.
  - dout_in is sampled at the edge ending the RD_LAT-th wait cycle, i.e. RD_LAT+1 edges after the edge that raised re_req.
  - Compare against the expected value. On mismatch: err_cnt increments, saturating at all-ones. If this is the first mismatch of the run, fail_addr=addr.
  - Then: if addr==DEPTH-1 -> DONE; otherwise addr+1 -> RD_REQ.
- DONE:
  - busy=0, done=1, pass=(err_cnt==0 including the final compare).
  - start=1 restarts exactly as from IDLE.
- Request exclusivity:
  - wr_req and re_req are never high in the same cycle.
  - Neither is high in consecutive cycles.
- start handling: start while busy is ignored.
- Run length: with defaults, done rises at the 160th edge after the start-sampling edge. General form: DEPTH*(1+GAP) + DEPTH*(1+RD_LAT) edges.

Optional Feature:
- Macro: SRAM_BIST_INV_PASS_EN.
- Defined: after the first read phase, run a second write phase with ~PATTERN, then a second read phase expecting ~PATTERN. err_cnt and fail_addr accumulate across both passes; fail_addr records the first mismatch in time. Default run is 320 edges.
- Undefined: single pattern pass as above. err_cnt width stays $clog2(2*DEPTH+1) in both builds.

Test Plan:
- Clean run: sram_top model, pulse start -> 32 wr_req pulses with din_out=4'b1010, then 32 re_req pulses; done at edge 160; pass=1, err_cnt=0, fail_addr=0.
- Stuck bit: model forces bit0 of all read data to 1 -> err_cnt=32, fail_addr=0, pass=0.
- Single fault: model returns 4'b0000 only at address 17 -> err_cnt=1, fail_addr=17, pass=0.
- start ignored: pulse start again at cycle 40 while busy -> no restart; done still at edge 160; addr sequence unchanged.
- Reset mid-run: assert rst asynchronously during RD_WAIT at address 5 -> all outputs 0 immediately, FSM IDLE. A new start completes a full clean run.
- Protocol check (both macro settings): assert wr_req/re_req never overlap or repeat back-to-back, and the addr_out sequence is 0..31 per phase. With SRAM_BIST_INV_PASS_EN defined, the second-pass din_out is 4'b0101 and done comes at edge 320.
